// File: rtl/sdram_arbit_pkg.sv
// sdram_arbit_pkg: shared FSM encoding and default sizing for the SDRAM round-robin arbiter.
// Rev 1.0
`default_nettype none

package sdram_arbit_pkg;

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_ARB  = 2'd1,
      S_REF  = 2'd2,
      S_CH   = 2'd3
   } state_t;

   localparam int DEF_N_CH       = 4;
   localparam int DEF_MAX_BURSTS = 2;
   localparam int DEF_REF_TMO    = 64;

endpackage

`default_nettype wire

// File: rtl/sdram_arbit_rr_pick.sv
// rr_pick: combinational rotating search, first set bit of req starting at ptr+1 modulo N_CH.
// Rev 1.0
`default_nettype none

module rr_pick #(
   parameter int N_CH = 4,
   parameter int ID_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic            found,
   output logic [ID_W-1:0] index
);

   logic [ID_W-1:0] cand;

   // Walk from the farthest candidate back to the nearest so the nearest one wins.
   always_comb begin
      found = |req;
      index = '0;
      cand  = '0;
      for (int i = N_CH; i >= 1; i--) begin
         cand = ID_W'((int'(ptr) + i) % N_CH);
         if (req[cand]) begin
            index = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sdram_arbit_rr.sv
// sdram_arbit_rr: SDRAM command-bus arbiter; refresh has priority, user channels share the bus round-robin.
// Rev 1.0
`default_nettype none

module sdram_arbit_rr
   import sdram_arbit_pkg::*;
#(
   parameter int N_CH       = DEF_N_CH,
   parameter int MAX_BURSTS = DEF_MAX_BURSTS,
   parameter int REF_TMO    = DEF_REF_TMO,
   parameter int ID_W       = $clog2(N_CH)
) (
   input  logic            sysclk_100M,
   input  logic            rst_n,
   input  logic            init_done,
   input  logic            ref_req,
   input  logic            ref_done,
   input  logic [N_CH-1:0] ch_req,
   input  logic [N_CH-1:0] ch_done,
   output logic            ref_gnt,
   output logic [N_CH-1:0] ch_gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            busy,
   output logic            ref_late
);

   localparam int WAIT_W = $clog2(REF_TMO + 1);

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [3:0]        burst_cnt, burst_cnt_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              ref_gnt_nxt;
   logic [N_CH-1:0]   ch_gnt_nxt;
   logic [ID_W-1:0]   gnt_id_nxt;
   logic              pick_found;
   logic [ID_W-1:0]   pick_index;
   logic              ch_release;

   rr_pick #(
      .N_CH (N_CH),
      .ID_W (ID_W)
   ) u_rr_pick (
      .req   (ch_req),
      .ptr   (rr_ptr),
      .found (pick_found),
      .index (pick_index)
   );

   // A burst hands the bus back when refresh is waiting, the owner is done, or its quota is spent.
   assign ch_release = ref_req || !ch_req[gnt_id] || (burst_cnt == 4'(MAX_BURSTS - 1));

   always_comb begin
      state_nxt     = state;
      ref_gnt_nxt   = ref_gnt;
      ch_gnt_nxt    = ch_gnt;
      gnt_id_nxt    = gnt_id;
      rr_ptr_nxt    = rr_ptr;
      burst_cnt_nxt = burst_cnt;
      case (state)
         S_INIT: begin
            ref_gnt_nxt = 1'b0;
            ch_gnt_nxt  = '0;
            if (init_done) begin
               state_nxt = S_ARB;
            end
         end
         S_ARB: begin
            if (ref_req) begin
               state_nxt   = S_REF;
               ref_gnt_nxt = 1'b1;
            end else if (pick_found) begin
               state_nxt              = S_CH;
               ch_gnt_nxt             = '0;
               ch_gnt_nxt[pick_index] = 1'b1;
               gnt_id_nxt             = pick_index;
               burst_cnt_nxt          = '0;
            end
         end
         S_REF: begin
            if (ref_done) begin
               state_nxt   = S_ARB;
               ref_gnt_nxt = 1'b0;
            end
         end
         S_CH: begin
            if (ch_done[gnt_id]) begin
               if (ch_release) begin
                  state_nxt  = S_ARB;
                  ch_gnt_nxt = '0;
                  rr_ptr_nxt = gnt_id;
               end else begin
                  burst_cnt_nxt = burst_cnt + 4'd1;
               end
            end
         end
         default: begin
            state_nxt   = S_INIT;
            ref_gnt_nxt = 1'b0;
            ch_gnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge sysclk_100M) begin
      if (!rst_n) begin
         state     <= S_INIT;
         ref_gnt   <= 1'b0;
         ch_gnt    <= '0;
         gnt_id    <= '0;
         busy      <= 1'b0;
         rr_ptr    <= ID_W'(N_CH - 1);
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         ref_gnt   <= ref_gnt_nxt;
         ch_gnt    <= ch_gnt_nxt;
         gnt_id    <= gnt_id_nxt;
         busy      <= ref_gnt_nxt | (|ch_gnt_nxt);
         rr_ptr    <= rr_ptr_nxt;
         burst_cnt <= burst_cnt_nxt;
      end
   end

   // Refresh starvation monitor; ref_late stays set until reset.
   always_ff @(posedge sysclk_100M) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         ref_late <= 1'b0;
      end else if (state != S_INIT && ref_req && !ref_gnt) begin
         if (wait_cnt != WAIT_W'(REF_TMO)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if (wait_cnt == WAIT_W'(REF_TMO - 1)) begin
            ref_late <= 1'b1;
         end
      end else if (ref_gnt) begin
         wait_cnt <= '0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbit_rr.sv
// tb_sdram_arbit_rr: directed scenario bench for the SDRAM round-robin arbiter (N_CH=4, MAX_BURSTS=2, REF_TMO=64).
// Rev 1.0
`default_nettype none

module tb_sdram_arbit_rr;
   import sdram_arbit_pkg::*;

   logic       sysclk_100M;
   logic       rst_n;
   logic       init_done;
   logic       ref_req;
   logic       ref_done;
   logic [3:0] ch_req;
   logic [3:0] ch_done;
   logic       ref_gnt;
   logic [3:0] ch_gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       ref_late;

   int tests_run;
   int tests_failed;

   sdram_arbit_rr #(
      .N_CH       (4),
      .MAX_BURSTS (2),
      .REF_TMO    (64)
   ) dut (
      .sysclk_100M (sysclk_100M),
      .rst_n       (rst_n),
      .init_done   (init_done),
      .ref_req     (ref_req),
      .ref_done    (ref_done),
      .ch_req      (ch_req),
      .ch_done     (ch_done),
      .ref_gnt     (ref_gnt),
      .ch_gnt      (ch_gnt),
      .gnt_id      (gnt_id),
      .busy        (busy),
      .ref_late    (ref_late)
   );

   initial sysclk_100M = 1'b0;
   always #5 sysclk_100M = ~sysclk_100M;

   task automatic tick();
      @(posedge sysclk_100M);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; init_done = 1'b0; ref_req = 1'b0; ref_done = 1'b0;
      ch_req = 4'b0000; ch_done = 4'b0000;
      tick(); tick();
      tests_run++; if (ch_gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_ch_gnt got %b want 0000", ch_gnt); end
      tests_run++; if (ref_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_ref_gnt got %b want 0", ref_gnt); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
      tests_run++; if (ref_late !== 1'b0) begin tests_failed++; $display("FAIL reset_ref_late got %b want 0", ref_late); end
      tests_run++; if (gnt_id !== 2'd0) begin tests_failed++; $display("FAIL reset_gnt_id got %0d want 0", gnt_id); end
      tests_run++; if (dut.state !== S_INIT) begin tests_failed++; $display("FAIL reset_state got %0d want S_INIT", dut.state); end
   endtask

   task automatic test_init_gating();
      rst_n = 1'b1; ch_req = 4'b0001;
      for (int i = 0; i < 50; i++) begin
         tick();
         tests_run++; if (ch_gnt !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL init_gate_cycle%0d got gnt=%b busy=%b want 0000/0", i, ch_gnt, busy); end
      end
      init_done = 1'b1;
      tick();
      tests_run++; if (ch_gnt !== 4'b0000) begin tests_failed++; $display("FAIL init_first_cycle got %b want 0000", ch_gnt); end
      tick();
      tests_run++; if (ch_gnt !== 4'b0001) begin tests_failed++; $display("FAIL init_grant got %b want 0001", ch_gnt); end
      tests_run++; if (gnt_id !== 2'd0) begin tests_failed++; $display("FAIL init_gnt_id got %0d want 0", gnt_id); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL init_busy got %b want 1", busy); end
      ch_req = 4'b0000; ch_done = 4'b0001;
      tick();
      ch_done = 4'b0000;
      tests_run++; if (ch_gnt !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL init_release got gnt=%b busy=%b want 0000/0", ch_gnt, busy); end
   endtask

   task automatic test_round_robin();
      int         order [9];
      logic [3:0] exp_gnt;
      order = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; ch_req = 4'b1111;
      tick();
      tick();
      for (int k = 0; k < 9; k++) begin
         exp_gnt = 4'b0001 << order[k];
         tests_run++; if (ch_gnt !== exp_gnt || gnt_id !== 2'(order[k])) begin tests_failed++; $display("FAIL rr_grant%0d got gnt=%b id=%0d want %b id=%0d", k, ch_gnt, gnt_id, exp_gnt, order[k]); end
         tick();
         tests_run++; if (ch_gnt !== exp_gnt) begin tests_failed++; $display("FAIL rr_hold%0d got %b want %b", k, ch_gnt, exp_gnt); end
         if (k == 8) ch_req = 4'b0000;
         ch_done = exp_gnt;
         tick();
         ch_done = 4'b0000;
         if (k < 8 && order[k+1] == order[k]) begin
            tests_run++; if (ch_gnt !== exp_gnt) begin tests_failed++; $display("FAIL rr_chain%0d got %b want %b", k, ch_gnt, exp_gnt); end
         end else begin
            tests_run++; if (ch_gnt !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL rr_gap%0d got gnt=%b busy=%b want 0000/0", k, ch_gnt, busy); end
            tick();
         end
      end
      tests_run++; if (ch_gnt !== 4'b0000) begin tests_failed++; $display("FAIL rr_idle got %b want 0000", ch_gnt); end
   endtask

   task automatic test_ref_priority();
      ref_req = 1'b1; ch_req = 4'b0010;
      tick();
      tests_run++; if (ref_gnt !== 1'b1 || ch_gnt !== 4'b0000) begin tests_failed++; $display("FAIL refpri_first got ref=%b gnt=%b want 1/0000", ref_gnt, ch_gnt); end
      ref_req = 1'b0;
      tick();
      tests_run++; if (ref_gnt !== 1'b1) begin tests_failed++; $display("FAIL refpri_hold got %b want 1", ref_gnt); end
      ref_done = 1'b1;
      tick();
      ref_done = 1'b0;
      tests_run++; if (ref_gnt !== 1'b0 || ch_gnt !== 4'b0000) begin tests_failed++; $display("FAIL refpri_gap got ref=%b gnt=%b want 0/0000", ref_gnt, ch_gnt); end
      tick();
      tests_run++; if (ch_gnt !== 4'b0010 || gnt_id !== 2'd1) begin tests_failed++; $display("FAIL refpri_ch got gnt=%b id=%0d want 0010 id=1", ch_gnt, gnt_id); end
   endtask

   task automatic test_ref_interrupt();
      ch_req = 4'b1101; ch_done = 4'b0010;
      tick();
      ch_done = 4'b0000;
      tick();
      tests_run++; if (ch_gnt !== 4'b0100) begin tests_failed++; $display("FAIL refint_ch2 got %b want 0100", ch_gnt); end
      ch_done = 4'b0001;
      tick();
      ch_done = 4'b0000;
      tests_run++; if (ch_gnt !== 4'b0100) begin tests_failed++; $display("FAIL refint_foreign_done got %b want 0100", ch_gnt); end
      ref_req = 1'b1;
      tick();
      tests_run++; if (ch_gnt !== 4'b0100 || ref_gnt !== 1'b0) begin tests_failed++; $display("FAIL refint_no_preempt got gnt=%b ref=%b want 0100/0", ch_gnt, ref_gnt); end
      ch_done = 4'b0100;
      tick();
      ch_done = 4'b0000;
      tests_run++; if (ch_gnt !== 4'b0000 || ref_gnt !== 1'b0) begin tests_failed++; $display("FAIL refint_gap got gnt=%b ref=%b want 0000/0", ch_gnt, ref_gnt); end
      tick();
      tests_run++; if (ref_gnt !== 1'b1 || ch_gnt !== 4'b0000) begin tests_failed++; $display("FAIL refint_ref got ref=%b gnt=%b want 1/0000", ref_gnt, ch_gnt); end
      ref_req = 1'b0; ref_done = 1'b1;
      tick();
      ref_done = 1'b0;
      tests_run++; if (ref_gnt !== 1'b0) begin tests_failed++; $display("FAIL refint_ref_end got %b want 0", ref_gnt); end
      tick();
      tests_run++; if (ch_gnt !== 4'b1000 || gnt_id !== 2'd3) begin tests_failed++; $display("FAIL refint_next got gnt=%b id=%0d want 1000 id=3", ch_gnt, gnt_id); end
      ch_req = 4'b0000; ch_done = 4'b1000;
      tick();
      ch_done = 4'b0000;
      tick();
   endtask

   task automatic test_timeout();
      ch_req = 4'b0001;
      tick();
      tests_run++; if (ch_gnt !== 4'b0001) begin tests_failed++; $display("FAIL tmo_grant got %b want 0001", ch_gnt); end
      ref_req = 1'b1;
      repeat (60) tick();
      tests_run++; if (ref_late !== 1'b0) begin tests_failed++; $display("FAIL tmo_early got %b want 0", ref_late); end
      tests_run++; if (ch_gnt !== 4'b0001 || ref_gnt !== 1'b0) begin tests_failed++; $display("FAIL tmo_hold got gnt=%b ref=%b want 0001/0", ch_gnt, ref_gnt); end
      repeat (6) tick();
      tests_run++; if (ref_late !== 1'b1) begin tests_failed++; $display("FAIL tmo_late got %b want 1", ref_late); end
      ch_req = 4'b0000; ch_done = 4'b0001;
      tick();
      ch_done = 4'b0000;
      tick();
      tests_run++; if (ref_gnt !== 1'b1) begin tests_failed++; $display("FAIL tmo_ref got %b want 1", ref_gnt); end
      ref_req = 1'b0; ref_done = 1'b1;
      tick();
      ref_done = 1'b0;
      tests_run++; if (ref_gnt !== 1'b0 || ref_late !== 1'b1) begin tests_failed++; $display("FAIL tmo_sticky got ref=%b late=%b want 0/1", ref_gnt, ref_late); end
      rst_n = 1'b0;
      tick();
      tests_run++; if (ref_late !== 1'b0) begin tests_failed++; $display("FAIL tmo_clear got %b want 0", ref_late); end
   endtask

   task automatic test_reset_mid_grant();
      rst_n = 1'b1; ch_req = 4'b0100;
      tick();
      tick();
      tests_run++; if (ch_gnt !== 4'b0100 || gnt_id !== 2'd2) begin tests_failed++; $display("FAIL midrst_grant got gnt=%b id=%0d want 0100 id=2", ch_gnt, gnt_id); end
      rst_n = 1'b0;
      tick();
      tests_run++; if (ch_gnt !== 4'b0000 || ref_gnt !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_drop got gnt=%b ref=%b busy=%b want 0000/0/0", ch_gnt, ref_gnt, busy); end
      tests_run++; if (dut.state !== S_INIT) begin tests_failed++; $display("FAIL midrst_state got %0d want S_INIT", dut.state); end
      rst_n = 1'b1; ch_req = 4'b0000;
      tick();
      tick();
      tests_run++; if (ch_gnt !== 4'b0000) begin tests_failed++; $display("FAIL midrst_idle got %b want 0000", ch_gnt); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_init_gating();
      test_round_robin();
      test_ref_priority();
      test_ref_interrupt();
      test_timeout();
      test_reset_mid_grant();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sdram_arbit_rr.md
SDRAM_ARBIT_RR -- requirements
Module: sdram_arbit_rr

Interface
REQ-001 Parameter N_CH, default 4: number of user request channels (2..8).
REQ-002 Parameter MAX_BURSTS, default 2: maximum consecutive bursts a channel may run before the grant rotates (1..15).
REQ-003 Parameter REF_TMO, default 64: number of cycles a refresh request may wait before ref_late is raised.
REQ-004 Parameter ID_W, derived as clog2(N_CH): width of gnt_id.
REQ-005 sysclk_100M  in  1  the single clock; all logic is on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 init_done  in  1  level; the SDRAM init sequence is complete.
REQ-008 ref_req  in  1  level; the refresh timer requests a refresh and holds until ref_gnt.
REQ-009 ref_done  in  1  one-cycle pulse; the refresh command sequence is finished.
REQ-010 ch_req  in  N_CH  level per channel; a read or write burst is pending.
REQ-011 ch_done  in  N_CH  one-cycle pulse per channel; the current burst is finished.
REQ-012 ref_gnt  out  1  the refresh engine owns the command bus.
REQ-013 ch_gnt  out  N_CH  one-hot (or zero) channel grant.
REQ-014 gnt_id  out  ID_W  index of the granted channel; holds its last value when no channel is granted.
REQ-015 busy  out  1  asserted when any grant is active.
REQ-016 ref_late  out  1  sticky; refresh waited more than REF_TMO cycles.

Function
REQ-017 The FSM has states S_INIT, S_ARB, S_REF and S_CH; all outputs are registered.
REQ-018 S_INIT: all grants are 0; the FSM moves to S_ARB on the first cycle that init_done=1; ch_req and ref_req are ignored until then.
REQ-019 S_ARB with ref_req=1: move to S_REF; ref_gnt=1 from the next cycle. Refresh beats every channel request that arrives in the same cycle.
REQ-020 S_ARB with ref_req=0 and any ch_req: grant the first requesting channel searching from rr_ptr+1 modulo N_CH; ch_gnt and gnt_id are valid the next cycle; burst_cnt is cleared.
REQ-021 S_ARB with no request: stay in S_ARB; busy=0.
REQ-022 S_REF: hold ref_gnt until ref_done; on ref_done, ref_gnt=0 next cycle and the FSM returns to S_ARB.
REQ-023 S_CH on ch_done[gnt_id]: the channel releases (return to S_ARB, rr_ptr=gnt_id) if ref_req=1, or ch_req[gnt_id]=0, or burst_cnt=MAX_BURSTS-1.
REQ-024 Otherwise on ch_done[gnt_id], the grant is held with no gap and burst_cnt increments.
REQ-025 Every release spends exactly one cycle in S_ARB with all grants 0 before the next grant.
REQ-026 ch_done bits of non-granted channels, and ref_done outside S_REF, are ignored.
REQ-027 ch_done[gnt_id] and ref_req rising in the same cycle: the burst ends and refresh is granted through S_ARB.
REQ-028 Worst-case wait for an always-requesting channel is (N_CH-1)*MAX_BURSTS bursts plus pending refreshes.
REQ-029 wait_cnt counts cycles with ref_req=1 and ref_gnt=0, saturates, and clears on ref_gnt.
REQ-030 ref_late is set when wait_cnt reaches REF_TMO.
REQ-031 rr_ptr wraps from N_CH-1 to 0.
REQ-032 At most one of ref_gnt and the ch_gnt bits is 1 in any cycle.

Reset
REQ-033 With rst_n=0 at a clock edge, the state is S_INIT and ref_gnt, ch_gnt, busy and ref_late are 0.
REQ-034 With rst_n=0 at a clock edge, gnt_id is 0, rr_ptr is N_CH-1 (so channel 0 wins first), and burst_cnt and wait_cnt are 0.
REQ-035 Reset mid-burst or mid-refresh drops the grant on the next edge; no done pulse is awaited.

Structure
REQ-036 Package sdram_arbit_pkg holds the state enumeration and the default values of N_CH, MAX_BURSTS and REF_TMO.
REQ-037 One combinational sub-module, rr_pick (inputs req vector and ptr; outputs found and index), implements the rotating search.

Verification (N_CH=4, MAX_BURSTS=2, REF_TMO=64)
REQ-038 Init gating: ch_req=4'b0001 with init_done=0 for 50 cycles -> no grant; raise init_done -> ch_gnt=4'b0001 two cycles later.
REQ-039 Round-robin: ch_req=4'b1111 held, ch_done pulsed each burst -> grant order 0,0,1,1,2,2,3,3,0 with one idle cycle between owners.
REQ-040 Refresh priority: ref_req and ch_req=4'b0010 rise together in S_ARB -> ref_gnt first; after ref_done, ch_gnt=4'b0010.
REQ-041 Refresh interrupts chaining: channel 2 on burst 1 of 2, ref_req rises, then ch_done[2] -> ch 2 released, ref_gnt, then the grant search starts from channel 3.
REQ-042 Timeout: channel 0 holds the bus without ch_done while ref_req=1 for 64 cycles -> ref_late=1 and it stays 1 after ref_done; rst_n=0 clears it.
REQ-043 Reset mid-grant: rst_n=0 for one cycle while ch_gnt=4'b0100 -> all grants 0 next cycle and the state is S_INIT.
